// File: rtl/mem_arbiter.sv
// mem_arbiter -- single-outstanding memory arbiter for fetch (IF), prefetch (PF)
// and load/store (LSB) requesters in front of one downstream memory port.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   rdy                 global enable; low freezes every register, masks mc_enable
//                       and the done pulses (a pending pulse appears once rdy returns)
//   clr                 pipeline flush; blocks new reads, squashes in-flight read results
//   if_*                fetch request / completion pulse + instruction word
//   pf_*                prefetch request / completion pulse + word
//   ls_*                load/store request, type, store value; load/store done pulses
//   mc_*                downstream request (held for the whole transaction) and
//                       downstream load/store completion with read data
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_data,
  input  logic              pf_req,
  input  logic [ADDR_W-1:0] pf_addr,
  output logic              pf_done,
  output logic [DATA_W-1:0] pf_data,
  input  logic              ls_req,
  input  logic              ls_wr,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [2:0]        ls_type,
  input  logic [DATA_W-1:0] ls_st_val,
  output logic              ls_ld_done,
  output logic              ls_st_done,
  output logic [DATA_W-1:0] ls_ld_val,
  output logic              mc_enable,
  output logic              mc_wr,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [2:0]        mc_ls_type,
  output logic [DATA_W-1:0] mc_st_val,
  input  logic              mc_ld_done,
  input  logic              mc_st_done,
  input  logic [DATA_W-1:0] mc_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, GAP} state_t;
  typedef enum logic [1:0] {OWN_IF, OWN_PF, OWN_LS} owner_t;

  state_t            state;
  owner_t            owner;
  logic              last_lsb;
  logic              if_done_q, pf_done_q, ld_done_q, st_done_q;
  logic [DATA_W-1:0] rdata_q;

  // ---------------------------------------------------------------
  // Grant selection (IDLE only). During a flush only committed stores
  // may start; PF only fills otherwise-idle slots.
  // ---------------------------------------------------------------
  logic   if_ok, ls_ok, pf_ok, grant_any;
  owner_t grant_own;

  always_comb begin
    if_ok     = if_req & ~clr;
    ls_ok     = ls_req & (ls_wr | ~clr);
    pf_ok     = pf_req & ~clr & ~if_req & ~ls_req;
    grant_any = if_ok | ls_ok | pf_ok;
    grant_own = OWN_PF;
    if (if_ok && ls_ok) grant_own = last_lsb ? OWN_IF : OWN_LS;
    else if (ls_ok)     grant_own = OWN_LS;
    else if (if_ok)     grant_own = OWN_IF;
  end

  logic mc_done, is_store;
  assign mc_done  = mc_ld_done | mc_st_done;
  assign is_store = (owner == OWN_LS) && mc_wr;

  // ---------------------------------------------------------------
  // FSM + latched request + done pulse registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      last_lsb   <= 1'b0;
      mc_wr      <= 1'b0;
      mc_addr    <= '0;
      mc_ls_type <= 3'b000;
      mc_st_val  <= '0;
      if_done_q  <= 1'b0;
      pf_done_q  <= 1'b0;
      ld_done_q  <= 1'b0;
      st_done_q  <= 1'b0;
      rdata_q    <= '0;
    end else if (rdy) begin
      // pulses live for exactly one enabled cycle
      if_done_q <= 1'b0;
      pf_done_q <= 1'b0;
      ld_done_q <= 1'b0;
      st_done_q <= 1'b0;
      rdata_q   <= '0;
      case (state)
        IDLE: if (grant_any) begin
          owner <= grant_own;
          state <= BUSY;
          case (grant_own)
            OWN_LS: begin
              mc_wr      <= ls_wr;
              mc_addr    <= ls_addr;
              mc_ls_type <= ls_type;
              mc_st_val  <= ls_st_val;
              last_lsb   <= 1'b1;
            end
            OWN_IF: begin
              mc_wr      <= 1'b0;
              mc_addr    <= if_addr;
              mc_ls_type <= 3'b111;
              mc_st_val  <= '0;
              last_lsb   <= 1'b0;
            end
            default: begin
              mc_wr      <= 1'b0;
              mc_addr    <= pf_addr;
              mc_ls_type <= 3'b111;
              mc_st_val  <= '0;
            end
          endcase
        end
        BUSY: begin
          // a flushed read still has to finish downstream; its result is dropped
          if (clr && !is_store) begin
            state <= mc_done ? GAP : DRAIN;
          end else if (mc_done) begin
            state <= GAP;
            case (owner)
              OWN_IF:  begin if_done_q <= 1'b1; rdata_q <= mc_rdata; end
              OWN_PF:  begin pf_done_q <= 1'b1; rdata_q <= mc_rdata; end
              default: begin
                if (mc_wr) st_done_q <= 1'b1;
                else begin ld_done_q <= 1'b1; rdata_q <= mc_rdata; end
              end
            endcase
          end
        end
        DRAIN: if (mc_done) state <= GAP;
        default: state <= IDLE;  // GAP
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Outputs: gated by rdy so a frozen cycle never shows a pulse; the
  // pulse register holds and appears on the first enabled cycle.
  // ---------------------------------------------------------------
  assign mc_enable  = rdy & ((state == BUSY) | (state == DRAIN));
  assign if_done    = rdy & if_done_q;
  assign pf_done    = rdy & pf_done_q;
  assign ls_ld_done = rdy & ld_done_q;
  assign ls_st_done = rdy & st_done_q;
  assign if_data    = if_done    ? rdata_q : '0;
  assign pf_data    = pf_done    ? rdata_q : '0;
  assign ls_ld_val  = ls_ld_done ? rdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays the downstream memory by
// driving mc_*_done by hand; every expected value is written out literally.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst, rdy, clr;
  logic        if_req, pf_req, ls_req, ls_wr;
  logic [31:0] if_addr, pf_addr, ls_addr, ls_st_val, mc_rdata;
  logic [2:0]  ls_type;
  logic        mc_ld_done, mc_st_done;
  logic        if_done, pf_done, ls_ld_done, ls_st_done;
  logic [31:0] if_data, pf_data, ls_ld_val;
  logic        mc_enable, mc_wr;
  logic [31:0] mc_addr, mc_st_val;
  logic [2:0]  mc_ls_type;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .pf_req(pf_req), .pf_addr(pf_addr), .pf_done(pf_done), .pf_data(pf_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_type(ls_type),
    .ls_st_val(ls_st_val), .ls_ld_done(ls_ld_done), .ls_st_done(ls_st_done),
    .ls_ld_val(ls_ld_val),
    .mc_enable(mc_enable), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_ls_type(mc_ls_type),
    .mc_st_val(mc_st_val), .mc_ld_done(mc_ld_done), .mc_st_done(mc_st_done),
    .mc_rdata(mc_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one-cycle downstream completion; returns in the cycle after the edge
  task automatic mem_done(input logic st, input logic [31:0] data);
    mc_ld_done = ~st;
    mc_st_done = st;
    mc_rdata   = data;
    tick();
    mc_ld_done = 1'b0;
    mc_st_done = 1'b0;
    mc_rdata   = 32'h0;
    #1;
  endtask

  initial begin
    rst = 1; rdy = 1; clr = 0;
    if_req = 0; pf_req = 0; ls_req = 0; ls_wr = 0;
    if_addr = 0; pf_addr = 0; ls_addr = 0; ls_st_val = 0; ls_type = 0;
    mc_ld_done = 0; mc_st_done = 0; mc_rdata = 0;
    tick(); tick();
    chk("rst_mc_enable", 32'(mc_enable), 32'h0);
    chk("rst_mc_wr",     32'(mc_wr), 32'h0);
    chk("rst_mc_addr",   mc_addr, 32'h0);
    chk("rst_mc_type",   32'(mc_ls_type), 32'h0);
    chk("rst_mc_stval",  mc_st_val, 32'h0);
    chk("rst_dones",     32'({if_done, pf_done, ls_ld_done, ls_st_done}), 32'h0);
    chk("rst_data",      if_data | pf_data | ls_ld_val, 32'h0);
    rst = 0;

    // basic fetch, done 4 cycles after grant
    if_req = 1; if_addr = 32'h1000;
    tick();
    chk("if_mc_enable", 32'(mc_enable), 32'h1);
    chk("if_mc_addr",   mc_addr, 32'h1000);
    chk("if_mc_type",   32'(mc_ls_type), 32'h7);
    chk("if_mc_wr",     32'(mc_wr), 32'h0);
    tick(); tick(); tick();
    chk("if_busy_hold", 32'(mc_enable), 32'h1);
    mem_done(1'b0, 32'h00C58593);
    chk("if_done",      32'(if_done), 32'h1);
    chk("if_data",      if_data, 32'h00C58593);
    chk("if_gap_en",    32'(mc_enable), 32'h0);
    if_req = 0;
    tick();
    chk("if_done_1cyc", 32'(if_done), 32'h0);
    chk("if_data_zero", if_data, 32'h0);

    // IF/LSB round robin: LSB, IF, LSB, IF
    if_req = 1; ls_req = 1; ls_wr = 0; ls_addr = 32'h2000; ls_type = 3'b010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_grant_addr", mc_addr, (i % 2 == 0) ? 32'h2000 : 32'h1000);
      chk("rr_grant_type", 32'(mc_ls_type), (i % 2 == 0) ? 32'h2 : 32'h7);
      mem_done(1'b0, 32'hA0 + 32'(i));
      chk("rr_ld_done", 32'(ls_ld_done), (i % 2 == 0) ? 32'h1 : 32'h0);
      chk("rr_if_done", 32'(if_done),    (i % 2 == 0) ? 32'h0 : 32'h1);
      chk("rr_gap_en",  32'(mc_enable), 32'h0);
      if (i == 3) begin if_req = 0; ls_req = 0; end
      tick();
      chk("rr_idle_en", 32'(mc_enable), 32'h0);
    end

    // PF waits for IF to go away
    if_req = 1; pf_req = 1; pf_addr = 32'h4000;
    tick();
    chk("pf_blocked", mc_addr, 32'h1000);
    mem_done(1'b0, 32'h11);
    chk("pf_if_done", 32'(if_done), 32'h1);
    if_req = 0;
    tick();
    tick();
    chk("pf_grant_addr", mc_addr, 32'h4000);
    chk("pf_grant_type", 32'(mc_ls_type), 32'h7);
    mem_done(1'b0, 32'hDEADBEEF);
    chk("pf_done", 32'(pf_done), 32'h1);
    chk("pf_data", pf_data, 32'hDEADBEEF);
    chk("pf_no_if", 32'(if_done), 32'h0);
    pf_req = 0;
    tick();

    // flushed load: drains, no done
    ls_req = 1; ls_wr = 0; ls_addr = 32'h2000; ls_type = 3'b010;
    tick();
    chk("fl_grant", mc_addr, 32'h2000);
    clr = 1;
    tick();
    clr = 0;
    #1;
    chk("fl_drain_en", 32'(mc_enable), 32'h1);
    tick();
    chk("fl_drain_en2", 32'(mc_enable), 32'h1);
    mem_done(1'b0, 32'h55);
    chk("fl_no_done", 32'(ls_ld_done), 32'h0);
    chk("fl_no_val",  ls_ld_val, 32'h0);
    chk("fl_gap_en",  32'(mc_enable), 32'h0);
    ls_req = 0;
    tick();
    chk("fl_no_done2", 32'(ls_ld_done), 32'h0);

    // store under continuous clr; IF also requesting but blocked
    clr = 1; if_req = 1;
    ls_req = 1; ls_wr = 1; ls_addr = 32'h30000; ls_st_val = 32'h41; ls_type = 3'b000;
    tick();
    chk("st_grant_addr", mc_addr, 32'h30000);
    chk("st_mc_wr",      32'(mc_wr), 32'h1);
    chk("st_mc_val",     mc_st_val, 32'h41);
    tick();
    chk("st_clr_no_drain", 32'(mc_enable), 32'h1);
    mem_done(1'b1, 32'h0);
    chk("st_done",  32'(ls_st_done), 32'h1);
    chk("st_no_if", 32'(if_done), 32'h0);
    ls_req = 0; ls_wr = 0; if_req = 0;
    tick();
    chk("st_done_1cyc", 32'(ls_st_done), 32'h0);
    clr = 0;

    // rdy freeze during BUSY, deferred pulse
    ls_req = 1; ls_addr = 32'h2004; ls_type = 3'b010;
    tick();
    chk("rdy_grant", mc_addr, 32'h2004);
    rdy = 0; #1;
    chk("rdy_en_low", 32'(mc_enable), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rdy_addr_hold", mc_addr, 32'h2004);
      chk("rdy_type_hold", 32'(mc_ls_type), 32'h2);
    end
    rdy = 1; #1;
    chk("rdy_en_back", 32'(mc_enable), 32'h1);
    mc_ld_done = 1; mc_rdata = 32'h77;
    tick();
    mc_ld_done = 0; mc_rdata = 0; rdy = 0; #1;
    chk("rdy_pulse_masked", 32'(ls_ld_done), 32'h0);
    tick();
    rdy = 1; #1;
    chk("rdy_pulse", 32'(ls_ld_done), 32'h1);
    chk("rdy_val",   ls_ld_val, 32'h77);
    ls_req = 0;
    tick();
    chk("rdy_single", 32'(ls_ld_done), 32'h0);

    // reset mid-BUSY with a done arriving on the same edge
    if_req = 1; if_addr = 32'h1234;
    tick();
    chk("rb_busy", 32'(mc_enable), 32'h1);
    rst = 1; mc_ld_done = 1; mc_rdata = 32'h99;
    tick();
    mc_ld_done = 0; mc_rdata = 0; #1;
    chk("rb_en",   32'(mc_enable), 32'h0);
    chk("rb_addr", mc_addr, 32'h0);
    chk("rb_type", 32'(mc_ls_type), 32'h0);
    chk("rb_done", 32'(if_done), 32'h0);
    rst = 0; if_req = 0;
    tick();
    chk("rb_done2", 32'(if_done), 32'h0);

    // clr and downstream done on the same cycle: squashed, straight to GAP
    if_req = 1; if_addr = 32'h1000;
    tick();
    chk("cd_grant", mc_addr, 32'h1000);
    clr = 1; mc_ld_done = 1; mc_rdata = 32'h66;
    tick();
    clr = 0; mc_ld_done = 0; mc_rdata = 0; if_req = 0; #1;
    chk("cd_no_done", 32'(if_done), 32'h0);
    chk("cd_gap_en",  32'(mc_enable), 32'h0);
    tick();
    chk("cd_idle_en", 32'(mc_enable), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end
endmodule
